// File: rtl/aes_key_expander_if.sv
// Request/response bundle between the AES key expander and its consumer.
// The cipher side (master) starts a run and reads round keys by index.
interface aes_key_expander_if #(
    parameter int RK_IDX_W = 4
);
    logic                start_i;
    logic [1:0]          mode_i;
    logic [255:0]        key_i;
    logic [RK_IDX_W-1:0] rk_idx_i;
    logic [127:0]        rk_o;
    logic                rk_valid_o;
    logic                busy_o;
    logic                done_o;
    logic                err_o;

    modport master (
        output start_i, mode_i, key_i, rk_idx_i,
        input  rk_o, rk_valid_o, busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, mode_i, key_i, rk_idx_i,
        output rk_o, rk_valid_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key expansion, one word per cycle into a readable round-key store.
// Optional AES_KS_ZEROIZE_EN adds zeroize_i and a clearable store.
module aes_key_expander #(
    parameter int MAX_KEY_BITS = 256,
    parameter int RK_IDX_W     = 4
) (
    input  logic clk_i,
    input  logic rst_i,
`ifdef AES_KS_ZEROIZE_EN
    input  logic zeroize_i,
`endif
    aes_key_expander_if.slave ks
);

    localparam int MAX_NR = (MAX_KEY_BITS >= 256) ? 14 : (MAX_KEY_BITS >= 192) ? 12 : 10;
    localparam int DEPTH  = 4 * (MAX_NR + 1);
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[8*(255-int'(x)) +: 8];
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   nk_q, nr_q, nk_in, nr_in;
    logic [CW-1:0] i_q, wcnt_q, last_i;
    logic [2:0]   kmod_q;
    logic [7:0]   rcon_q;
    logic         err_q;
    logic [127:0] rk_q;
    logic         rk_valid_q;
    logic [31:0]  mem [DEPTH];

    logic         kill, mode_ok, start_acc, start_rej, at_end, expand_step;
    logic [31:0]  w_prev, w_old, sub_in, sub_out, temp, w_new;

`ifdef AES_KS_ZEROIZE_EN
    assign kill = rst_i | zeroize_i;
`else
    assign kill = rst_i;
`endif

    always_comb begin
        mode_ok = 1'b1;
        nk_in   = 4'd4;
        nr_in   = 4'd10;
        case (ks.mode_i)
            2'b00: ;
            2'b01: begin nk_in = 4'd6; nr_in = 4'd12; mode_ok = (MAX_KEY_BITS >= 192); end
            2'b10: begin nk_in = 4'd8; nr_in = 4'd14; mode_ok = (MAX_KEY_BITS >= 256); end
            default: mode_ok = 1'b0;
        endcase
    end

    assign start_acc   = ks.start_i & mode_ok & ~kill;
    assign start_rej   = ks.start_i & ~mode_ok & ~kill;
    assign last_i      = CW'({nr_q, 2'b00}) + CW'(4);
    assign at_end      = (i_q == last_i);
    assign expand_step = (state_q == S_EXPAND) & ~at_end & ~start_acc & ~kill;

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (kill) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // FSM: next state; a legal start restarts from any state
    always_comb begin
        state_d = state_q;
        if (start_acc)                             state_d = S_EXPAND;
        else if (state_q == S_EXPAND && at_end)    state_d = S_DONE;
    end

    // FSM: outputs
    always_comb begin
        ks.busy_o = 1'b0;
        ks.done_o = 1'b0;
        case (state_q)
            S_EXPAND: ks.busy_o = 1'b1;
            S_DONE:   ks.done_o = 1'b1;
            default: ;
        endcase
    end

    // One expansion step; the single SubWord unit serves both the rotated and plain cases.
    always_comb begin
        w_prev  = mem[AW'(i_q - CW'(1))];
        w_old   = mem[AW'(i_q - CW'(nk_q))];
        sub_in  = (kmod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
        if (kmod_q == 3'd0)                      temp = sub_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && kmod_q == 3'd4) temp = sub_out;
        else                                     temp = w_prev;
        w_new = w_old ^ temp;
    end

    always_ff @(posedge clk_i) begin
        if (kill) begin
            nk_q   <= 4'd4;
            nr_q   <= 4'd10;
            i_q    <= '0;
            wcnt_q <= '0;
            kmod_q <= '0;
            rcon_q <= 8'h01;
        end else if (start_acc) begin
            nk_q   <= nk_in;
            nr_q   <= nr_in;
            i_q    <= CW'(nk_in);
            wcnt_q <= CW'(nk_in);
            kmod_q <= '0;
            rcon_q <= 8'h01;
        end else if (expand_step) begin
            i_q    <= i_q + CW'(1);
            wcnt_q <= wcnt_q + CW'(1);
            kmod_q <= ({1'b0, kmod_q} == nk_q - 4'd1) ? 3'd0 : kmod_q + 3'd1;
            if (kmod_q == 3'd0)
                rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)          err_q <= 1'b0;
        else if (start_acc) err_q <= 1'b0;
        else if (start_rej) err_q <= 1'b1;
    end

    // Without zeroize the store is plain datapath flops; stale contents are hidden by wcnt.
    always_ff @(posedge clk_i) begin
`ifdef AES_KS_ZEROIZE_EN
        if (kill) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else
`endif
        if (start_acc) begin
            for (int k = 0; k < 8; k++)
                if (k < int'(nk_in)) mem[k] <= ks.key_i[255-32*k -: 32];
        end else if (expand_step) begin
            mem[AW'(i_q)] <= w_new;
        end
    end

    logic [RK_IDX_W-1:0] rd_idx;
    logic                r_ok, r_full;
    logic [AW-1:0]       rd_base;
    logic [127:0]        rk_data;

    // Validity uses wcnt before this edge, so a word written this cycle reads as not yet valid.
    always_comb begin
        rd_idx  = ks.rk_idx_i;
        r_ok    = (wcnt_q != '0) && (int'(rd_idx) <= int'(nr_q));
        r_full  = int'(wcnt_q) >= 4 * int'(rd_idx) + 4;
        rd_base = r_ok ? AW'(4 * int'(rd_idx)) : '0;
        rk_data = {mem[rd_base], mem[rd_base + AW'(1)], mem[rd_base + AW'(2)], mem[rd_base + AW'(3)]};
    end

    always_ff @(posedge clk_i) begin
        if (kill) begin
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
        end else begin
            rk_q       <= r_ok ? rk_data : '0;
            rk_valid_q <= r_ok & r_full;
        end
    end

    assign ks.rk_o       = rk_q;
    assign ks.rk_valid_o = rk_valid_q;
    assign ks.err_o      = err_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: a driver pushes expectations from an
// algebraic AES key-schedule model, a negedge monitor pops and compares.
module tb_aes_key_expander;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic clk = 1'b0;
    logic rst;
`ifdef AES_KS_ZEROIZE_EN
    logic zer;
`endif

    aes_key_expander_if #(.RK_IDX_W(4)) ks ();

    aes_key_expander #(.MAX_KEY_BITS(256), .RK_IDX_W(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
`ifdef AES_KS_ZEROIZE_EN
        .zeroize_i (zer),
`endif
        .ks        (ks)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        int           idx;
        bit           chk_d;
        bit           v;
        logic [127:0] d;
        bit           busy;
        bit           done;
        bit           err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: S-box from GF(2^8) inverse + affine map, schedule from the textbook loop.
    byte unsigned sbx[256];
    logic [31:0]  m_w[60];
    int           m_nk = 4, m_nr = 0, m_s = 0;
    bit           m_live = 0, m_err = 0;

    function automatic byte unsigned gmul(input byte unsigned a, input byte unsigned b);
        byte unsigned p = 0;
        byte unsigned x = a;
        byte unsigned y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic byte unsigned rotl8(input byte unsigned b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbx[x[31:24]], sbx[x[23:16]], sbx[x[15:8]], sbx[x[7:0]]};
    endfunction

    function automatic logic [255:0] rkey();
        logic [255:0] k;
        for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
        return k;
    endfunction

    task automatic model_load(input logic [1:0] md, input logic [255:0] key);
        logic [31:0] t;
        byte unsigned rc = 8'h01;
        m_nk = 4 + 2 * int'(md);
        m_nr = 10 + 2 * int'(md);
        for (int i = 0; i < m_nk; i++) m_w[i] = key[255-32*i -: 32];
        for (int i = m_nk; i < 4 * (m_nr + 1); i++) begin
            t = m_w[i-1];
            if (i % m_nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (m_nk == 8 && i % 8 == 4) begin
                t = subw(t);
            end
            m_w[i] = m_w[i-m_nk] ^ t;
        end
    endtask

    task automatic chk(input string nm, input int c, input logic [127:0] act, input logic [127:0] exq);
        n_vec++;
        if (act !== exq) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, exq);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.due != cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL stale_item cyc=%0d got=due%0d want=due%0d", cyc, mon_e.due, cyc);
            end else begin
                chk("rk_valid", cyc, 128'(ks.rk_valid_o), 128'(mon_e.v));
                if (mon_e.chk_d) chk($sformatf("rk_data[%0d]", mon_e.idx), cyc, ks.rk_o, mon_e.d);
                chk("busy", cyc, 128'(ks.busy_o), 128'(mon_e.busy));
                chk("done", cyc, 128'(ks.done_o), 128'(mon_e.done));
                chk("err",  cyc, 128'(ks.err_o),  128'(mon_e.err));
            end
        end
    end

    // Drive one cycle of inputs and push what the DUT must show after the coming edge.
    task automatic step(input bit st, input logic [1:0] md, input logic [255:0] key, input int idx,
                        input bit rs, input bit zr, input bit ken, input logic [127:0] kv);
        exp_t e;
        int   ee, wc, total;
        @(negedge clk);
        ks.start_i  = st;
        ks.mode_i   = md;
        ks.key_i    = key;
        ks.rk_idx_i = 4'(idx);
        rst         = rs;
`ifdef AES_KS_ZEROIZE_EN
        zer         = zr;
`endif
        ee    = cyc + 1;
        e.due = ee;
        e.idx = idx;
        total = 4 * (m_nr + 1);
        wc    = 0;
        if (m_live) wc = (m_nk + ee - 1 - m_s < total) ? m_nk + ee - 1 - m_s : total;
        if (rs || zr || !m_live || idx > m_nr) begin
            e.v = 0; e.chk_d = 1; e.d = '0;
        end else begin
            e.v = (wc >= 4 * idx + 4);
            e.chk_d = e.v;
            e.d = {m_w[4*idx], m_w[4*idx+1], m_w[4*idx+2], m_w[4*idx+3]};
        end
        if (ken) begin
            e.v = 1; e.chk_d = 1; e.d = kv;
        end
        if (rs || zr) begin
            m_live = 0;
            if (rs) m_err = 0;
        end else if (st) begin
            if (md != 2'b11) begin
                model_load(md, key);
                m_s = ee; m_live = 1; m_err = 0;
            end else begin
                m_err = 1;
            end
        end
        total  = 4 * (m_nr + 1);
        e.busy = m_live && (ee - m_s) <= total - m_nk;
        e.done = m_live && !e.busy;
        e.err  = m_err;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 2'b00, '0, $urandom_range(0, 15), 0, 0, 0, '0);
    endtask

    task automatic go(input logic [1:0] md, input logic [255:0] key);
        step(1, md, key, $urandom_range(0, 15), 0, 0, 0, '0);
    endtask

    task automatic kat(input int idx, input logic [127:0] kv);
        step(0, 2'b00, '0, idx, 0, 0, 1, kv);
    endtask

    task automatic sweep();
        for (int r = 0; r < 16; r++) step(0, 2'b00, '0, r, 0, 0, 0, '0);
    endtask

    initial begin
        for (int x = 0; x < 256; x++) begin
            byte unsigned inv = 0;
            byte unsigned b;
            if (x != 0) begin
                inv = 8'h01;
                repeat (254) inv = gmul(inv, 8'(x));
            end
            b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbx[x] = b;
        end
        rst = 1'b1;
        ks.start_i = 1'b0; ks.mode_i = 2'b00; ks.key_i = '0; ks.rk_idx_i = '0;
`ifdef AES_KS_ZEROIZE_EN
        zer = 1'b0;
`endif
        repeat (3) step(0, 2'b00, '0, $urandom_range(0, 15), 1, 0, 0, '0);

        go(2'b00, K128); idle(44); kat(10, R128_10); step(0, 2'b00, '0, 11, 0, 0, 0, '0);
        go(2'b01, K192); idle(50); kat(12, R192_12);

        step(0, 2'b00, '0, 0, 1, 0, 0, '0);
        step(1, 2'b10, K256, 1, 0, 0, 0, '0);
        repeat (3) step(0, 2'b00, '0, 1, 0, 0, 0, '0);
        idle(55); kat(14, R256_14);

        step(1, 2'b11, rkey(), 3, 0, 0, 0, '0);
        kat(14, R256_14); idle(2);
        go(2'b00, K128); idle(45); kat(10, R128_10);

        go(2'b00, rkey()); idle(19); go(2'b10, K256); idle(55); kat(14, R256_14);

        go(2'b01, rkey()); idle(9);
        step(0, 2'b00, '0, 0, 1, 0, 0, '0);
        sweep();
        step(1, 2'b00, K128, 0, 1, 0, 0, '0);
        idle(2);
`ifdef AES_KS_ZEROIZE_EN
        go(2'b01, K192); idle(9);
        step(1, 2'b00, K128, 0, 0, 1, 0, '0);
        sweep();
`endif

        for (int t = 0; t < 24; t++) begin
            int n;
            go(2'($urandom_range(0, 3)), rkey());
            n = $urandom_range(5, 60);
            for (int k = 0; k < n; k++)
                step($urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)), rkey(),
                     $urandom_range(0, 15), $urandom_range(0, 99) == 0, 0, 0, '0);
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Parametrised, iterative AES key expansion for 128/192/256-bit keys, selected per run. One expanded 32-bit word is produced per cycle and held in an internal round-key store. The cipher datapath reads the store by round index while expansion is still running, so it can start round 0 before the last key is ready. The block replaces the fixed-width gated-clock key schedule and serves both the crypto-extension core and standalone AES engines.

## Interface
- MAX_KEY_BITS, 256, largest key size supported (128, 192 or 256); sets store depth to 4*(MAX_NR+1) words, with MAX_NR = 10/12/14.
- RK_IDX_W, 4, width of the round-index port.
- clk_i  in  1  single clock; all logic on posedge clk_i.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start a new expansion; single-cycle pulse, level ignored after acceptance.
- mode_i  in  2  key size, sampled with start_i: 00=128, 01=192, 10=256, 11=illegal.
- key_i  in  256  cipher key, sampled with start_i; a 128-bit key sits in [255:128], a 192-bit key in [255:64], and unused LSBs are ignored.
- rk_idx_i  in  RK_IDX_W  round-key index to read.
- rk_o  out  128  round key rk_idx_i, registered, word W[4r] in [127:96].
- rk_valid_o  out  1  rk_o holds a fully written key for the index sampled last cycle.
- busy_o  out  1  expansion in progress.
- done_o  out  1  all round keys for the current mode are valid.
- err_o  out  1  last start request was rejected.
- zeroize_i  in  1  present only with AES_KS_ZEROIZE_EN.

## Operation
- States: IDLE, EXPAND, DONE.
- **Start accepted** (start_i=1 and legal mode, in any state):
  - Latch Nk (4/6/8) and Nr (10/12/14).
  - Write W[0..Nk-1] from key_i.
  - Set i=Nk, rcon=0x01, kmod=0, written count wcnt=Nk.
  - Go to EXPAND.
- **Restart:** start_i during EXPAND or DONE restarts and discards previous keys, because wcnt is reset.
- **Rejected start:** illegal mode, or key size > MAX_KEY_BITS.
  - Set err_o=1; state, store and wcnt are unchanged.
  - err_o stays set until the next accepted start.
- **EXPAND step**, one word per cycle:
  - temp=W[i-1].
  - If kmod==0: temp=SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon=xtime(rcon) (0x80→0x1b).
  - Else if Nk==8 and kmod==4: temp=SubWord(temp).
  - W[i]=W[i-Nk]^temp; i++, wcnt++, kmod = (kmod==Nk-1) ? 0 : kmod+1.
- SubWord is one shared unit of four forward S-boxes, combinational within the step cycle.
- **Termination:** after writing W[4*Nr+3], go to DONE.
- **Read port:**
  - rk_o is registered from words W[4r..4r+3].
  - rk_valid_o=1 when wcnt ≥ 4r+4 and r ≤ Nr.
  - If r > Nr, or the store has been invalidated: rk_o=0, rk_valid_o=0.
  - Reading the word being written in the same cycle returns the old contents with rk_valid_o=0.
- **Outputs by state:** busy_o=1 in EXPAND only; done_o=1 in DONE only.

## Timing
- Reset values:
  - state IDLE, wcnt=0.
  - rk_o=0, rk_valid_o=0, busy_o=0, done_o=0, err_o=0.
- Start is accepted at edge 0; busy_o rises after that edge.
- done_o rises after edge 41 (AES-128), 47 (AES-192) or 53 (AES-256): 1 + (4*(Nr+1) - Nk).
- Round key r becomes readable after edge 4r+4-Nk+1 for r ≥ 1; round 0 (AES-128) or rounds 0–1 (AES-256) are readable after edge 1.
- Read latency is 1 cycle: rk_idx_i sampled at edge n gives rk_o/rk_valid_o after edge n.
- Reset mid-expansion returns to IDLE in the same edge; partial keys become unreadable (wcnt=0).
- start_i together with rst_i: reset wins.

## Configuration
- **AES_KS_ZEROIZE_EN defined:**
  - zeroize_i port exists.
  - zeroize_i=1 or rst_i clears every stored word to 0 in one cycle and forces IDLE and wcnt=0.
  - zeroize_i together with start_i: zeroize wins and start is dropped.
- **Not defined:**
  - The port is absent.
  - Store words have no reset (datapath flops only); invalidation relies on wcnt alone.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> done_o after edge 41; rk_idx_i=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx_i=11 gives rk_valid_o=0, rk_o=0.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done_o after edge 47; round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done_o after edge 53; round 14 = fe4890d1e6188d0b046df344706c631e; poll rk_idx_i=1 from edge 0 and see rk_valid_o first at 1.
- mode_i=11 with start_i -> err_o=1, busy_o=0, previous done keys still readable; a following legal start clears err_o.
- Restart at edge 20 of an AES-128 run with the AES-256 key -> all round indices invalid until rewritten; final keys match the AES-256 vector.
- rst_i (and zeroize_i when AES_KS_ZEROIZE_EN is defined) at edge 10 -> all outputs 0 next cycle, rk_valid_o=0 for every index.
